// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard/stall controller.
// The master side drives the pipeline status; the slave side returns the control enables.
interface hazard_stall_ctrl_if;
    logic [6:0]  IF_ID_op_i;
    logic [4:0]  IF_ID_rs1_i;
    logic [4:0]  IF_ID_rs2_i;
    logic        ID_EX_MemRead_i;
    logic [4:0]  ID_EX_rd_i;
    logic        Branch_taken_i;
    logic        mem_stall_i;
    logic        NoOp_o;
    logic        PCWrite_o;
    logic        IF_ID_Write_o;
    logic        Flush_o;
    logic        Pipe_Stall_o;
    logic        hung_o;
    logic [15:0] stall_cycles_o;
    logic [15:0] flush_cnt_o;

    modport master (
        output IF_ID_op_i, IF_ID_rs1_i, IF_ID_rs2_i, ID_EX_MemRead_i, ID_EX_rd_i,
               Branch_taken_i, mem_stall_i,
        input  NoOp_o, PCWrite_o, IF_ID_Write_o, Flush_o, Pipe_Stall_o, hung_o,
               stall_cycles_o, flush_cnt_o
    );

    modport slave (
        input  IF_ID_op_i, IF_ID_rs1_i, IF_ID_rs2_i, ID_EX_MemRead_i, ID_EX_rd_i,
               Branch_taken_i, mem_stall_i,
        output NoOp_o, PCWrite_o, IF_ID_Write_o, Flush_o, Pipe_Stall_o, hung_o,
               stall_cycles_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch / memory-stall controller for a 5-stage pipeline, with a
// sticky lock-up detector for memory stalls that never end.
module hazard_stall_ctrl #(
    parameter int TIMEOUT = 1024
) (
    input  logic               clk_i,
    input  logic               rst_i,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, HUNG} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [15:0] wait_cnt;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic        rs1_used, rs2_used, load_use;
    logic        noop, pc_write, if_id_write, flush, pipe_stall, hung;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Only R, I-ALU, load, store and branch formats carry real register operands.
    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (bus.IF_ID_op_i)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            7'b0010011, 7'b0000011: rs1_used = 1'b1;
            default: ;
        endcase
    end

    assign load_use = bus.ID_EX_MemRead_i && (bus.ID_EX_rd_i != 5'd0) &&
                      ((rs1_used && (bus.ID_EX_rd_i == bus.IF_ID_rs1_i)) ||
                       (rs2_used && (bus.ID_EX_rd_i == bus.IF_ID_rs2_i)));

    always_comb begin
        state_nxt   = state;
        noop        = 1'b0;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        flush       = 1'b0;
        pipe_stall  = 1'b0;
        hung        = 1'b0;
        case (state)
            HUNG: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                pipe_stall  = 1'b1;
                hung        = 1'b1;
            end
            default: begin
                if (bus.mem_stall_i) begin
                    pipe_stall  = 1'b1;
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    state_nxt   = (wait_cnt == WAIT_LAST) ? HUNG : MEM_WAIT;
                end else begin
                    state_nxt = RUN;
                    if (load_use) begin
                        // A taken branch seen here is simply retried once the bubble clears.
                        noop        = 1'b1;
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                    end else if (bus.Branch_taken_i) begin
                        flush = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= RUN;
            wait_cnt  <= 16'd0;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            state <= state_nxt;
            if (state != HUNG) begin
                wait_cnt <= bus.mem_stall_i ? wait_cnt + 16'd1 : 16'd0;
                if (pipe_stall || noop) stall_cnt <= sat_inc(stall_cnt);
                if (flush)              flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

    assign bus.NoOp_o         = noop;
    assign bus.PCWrite_o      = pc_write;
    assign bus.IF_ID_Write_o  = if_id_write;
    assign bus.Flush_o        = flush;
    assign bus.Pipe_Stall_o   = pipe_stall;
    assign bus.hung_o         = hung;
    assign bus.stall_cycles_o = stall_cnt;
    assign bus.flush_cnt_o    = flush_cnt;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: load-use decode, priorities, timeout
// lock-up, asynchronous reset and counter saturation.
module tb_hazard_stall_ctrl;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl #(.TIMEOUT(4)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    // Control vector order: {NoOp, PCWrite, IF_ID_Write, Flush, Pipe_Stall, hung}
    localparam logic [5:0] C_NORM  = 6'b011000;
    localparam logic [5:0] C_LU    = 6'b100000;
    localparam logic [5:0] C_FLUSH = 6'b011100;
    localparam logic [5:0] C_MEM   = 6'b000010;
    localparam logic [5:0] C_HUNG  = 6'b000011;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_S  = 7'b0100011;

    function automatic logic [5:0] ctl();
        return {bus.NoOp_o, bus.PCWrite_o, bus.IF_ID_Write_o,
                bus.Flush_o, bus.Pipe_Stall_o, bus.hung_o};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic mr, input logic [4:0] rd, input logic br, input logic ms);
        bus.IF_ID_op_i      = op;
        bus.IF_ID_rs1_i     = rs1;
        bus.IF_ID_rs2_i     = rs2;
        bus.ID_EX_MemRead_i = mr;
        bus.ID_EX_rd_i      = rd;
        bus.Branch_taken_i  = br;
        bus.mem_stall_i     = ms;
        #1;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        apply(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst_i = 1'b1;
        #1;
        check_val("rst_ctl", 32'(ctl()), 32'(C_NORM));
        check_val("rst_stall_cnt", 32'(bus.stall_cycles_o), 32'd0);
        check_val("rst_flush_cnt", 32'(bus.flush_cnt_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // Load-use on rs2 of an R-type, and its rd=x0 variant
        apply(OP_R, 5'd5, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);
        check_val("lu_rtype", 32'(ctl()), 32'(C_LU));
        tick();
        apply(OP_R, 5'd5, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        check_val("lu_rd0", 32'(ctl()), 32'(C_NORM));
        tick();

        // rs2 field ignored for I-ALU, used for stores
        apply(OP_I, 5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);
        check_val("rs2_unused", 32'(ctl()), 32'(C_NORM));
        tick();
        apply(OP_S, 5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);
        check_val("rs2_store", 32'(ctl()), 32'(C_LU));
        tick();
        check_val("stall_cnt_2", 32'(bus.stall_cycles_o), 32'd2);

        // Load-use wins over a taken branch; the branch flushes next cycle
        apply(OP_R, 5'd5, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0);
        check_val("lu_over_br", 32'(ctl()), 32'(C_LU));
        tick();
        apply(OP_R, 5'd5, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0);
        check_val("br_flush", 32'(ctl()), 32'(C_FLUSH));
        tick();
        check_val("flush_cnt_1", 32'(bus.flush_cnt_o), 32'd1);
        check_val("stall_cnt_3", 32'(bus.stall_cycles_o), 32'd3);

        // Memory stall hides a pending load-use for 3 cycles, then the bubble
        do_reset();
        for (int i = 0; i < 3; i++) begin
            apply(OP_R, 5'd5, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1);
            check_val($sformatf("mem_lu_%0d", i), 32'(ctl()), 32'(C_MEM));
            tick();
        end
        apply(OP_R, 5'd5, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);
        check_val("mem_then_lu", 32'(ctl()), 32'(C_LU));
        tick();
        check_val("mem_stall_cnt", 32'(bus.stall_cycles_o), 32'd4);
        check_val("mem_no_flush", 32'(bus.flush_cnt_o), 32'd0);

        // Timeout: 4 stalled cycles, lock-up from cycle 5
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            apply(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
            check_val($sformatf("to_wait_%0d", i), 32'(ctl()), 32'(C_MEM));
            tick();
        end
        check_val("to_hung_c5", 32'(ctl()), 32'(C_HUNG));
        tick();
        apply(OP_R, 5'd5, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0);
        check_val("hung_sticky", 32'(ctl()), 32'(C_HUNG));
        tick();
        tick();
        check_val("hung_stall_frozen", 32'(bus.stall_cycles_o), 32'd4);
        check_val("hung_flush_frozen", 32'(bus.flush_cnt_o), 32'd0);

        // Asynchronous reset mid-cycle leaves HUNG immediately
        apply(7'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        rst_i = 1'b1;
        #1;
        check_val("async_rst_hung", 32'(bus.hung_o), 32'd0);
        check_val("async_rst_cnt", 32'(bus.stall_cycles_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        apply(OP_R, 5'd5, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);
        check_val("post_rst_run", 32'(ctl()), 32'(C_LU));

        // Saturation of the stall counter
        do_reset();
        apply(OP_R, 5'd5, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);
        repeat (65534) tick();
        check_val("sat_65534", 32'(bus.stall_cycles_o), 32'h0000FFFE);
        tick();
        check_val("sat_65535", 32'(bus.stall_cycles_o), 32'h0000FFFF);
        tick();
        check_val("sat_hold", 32'(bus.stall_cycles_o), 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
